flash_boot_loader: RTL and testbench

- Boot-time copier directly upstream of the byte-enabled 8 KiB data memory.
- Reads NUM_BYTES from the S25FL128S SPI flash using the READ command (0x03) and writes each byte into the data memory through its write_i / be_sel_i / addr_i / data_i port.
- Used in builds without a preloaded memory image; holds the rest of the system off via busy_o until the copy finishes.

---
 rtl/flash_boot_loader_if.sv | 19 +
 rtl/flash_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_flash_boot_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/flash_boot_loader_if.sv
// flash_boot_loader_if: SPI flash pins and data-memory write port of the boot loader
interface flash_boot_loader_if;
  logic        spi_sck_o;
  logic        spi_cs_no;
  logic        spi_mosi_o;
  logic        spi_miso_i;
  logic        mem_write_o;
  logic [3:0]  mem_be_sel_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_data_o;
  modport master (
    output spi_sck_o, spi_cs_no, spi_mosi_o, mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o,
    input  spi_miso_i
  );
  modport slave (
    input  spi_sck_o, spi_cs_no, spi_mosi_o, mem_write_o, mem_be_sel_o, mem_addr_o, mem_data_o,
    output spi_miso_i
  );
endinterface

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies NUM_BYTES from SPI flash (READ 0x03) into the byte-enabled data memory
module flash_boot_loader #(
  parameter int          NUM_BYTES  = 8192,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          SCK_DIV    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  flash_boot_loader_if.master bus,
  output logic                busy_o,
  output logic                done_o
);
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [13:0] K_LAST = 14'(NUM_BYTES - 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;
  state_t r_state, w_state;
  logic [DW-1:0] r_div, w_div;
  logic r_sck, w_sck, r_cs_n, w_cs_n, r_mosi, w_mosi;
  logic [31:0] r_tx, w_tx;
  logic [4:0] r_cnt, w_cnt;
  logic [7:0] r_rx, w_rx;
  logic r_pend, w_pend, r_last, w_last;
  logic [13:0] r_k, w_k;
  logic r_wr, w_wr;
  logic [3:0] r_be, w_be;
  logic [12:0] r_addr, w_addr;
  logic [31:0] r_data, w_data;
  logic r_busy, w_busy, r_done, w_done;
  logic w_act, w_exp, w_go, w_rise, w_fall, w_stop;
  assign w_act  = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
  assign w_exp  = w_act && (r_div == DIV_LAST);
  assign w_go   = start_i && ((r_state == IDLE) || (r_state == DONE));
  assign w_rise = w_exp && !r_sck && !r_last;
  assign w_fall = w_exp && r_sck;
  assign w_stop = w_exp && !r_sck && r_last;
  // next-state and output logic: SCK half-period engine, shifters, byte writer
  always_comb begin
    w_state = r_state;
    w_div   = (w_act && !w_exp) ? r_div + 1'b1 : '0;
    w_sck   = r_sck;
    w_cs_n  = r_cs_n;
    w_mosi  = r_mosi;
    w_tx    = r_tx;
    w_cnt   = r_cnt;
    w_rx    = r_rx;
    w_pend  = r_pend;
    w_last  = r_last;
    w_k     = r_k;
    w_wr    = 1'b0;
    w_be    = r_be;
    w_addr  = r_addr;
    w_data  = r_data;
    w_busy  = r_busy;
    w_done  = r_done;
    if (w_go) begin
      w_state = CMD;
      w_div   = '0;
      w_sck   = 1'b0;
      w_cs_n  = 1'b0;
      w_mosi  = CMD_READ[7];
      w_tx    = {CMD_READ[6:0], FLASH_BASE, 1'b0};
      w_cnt   = '0;
      w_pend  = 1'b0;
      w_last  = 1'b0;
      w_k     = '0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
    end
    if (w_rise) begin
      w_sck = 1'b1;
      w_cnt = r_cnt + 5'd1;
      w_rx  = (r_state == DATA) ? {r_rx[6:0], bus.spi_miso_i} : r_rx;
      if (r_state == CMD && r_cnt == 5'd7) begin
        w_state = ADDR;
        w_cnt   = '0;
      end
      if (r_state == ADDR && r_cnt == 5'd23) begin
        w_state = DATA;
        w_cnt   = '0;
      end
      if (r_state == DATA && r_cnt == 5'd7) begin
        w_cnt  = '0;
        w_pend = 1'b1;
        w_last = (r_k == K_LAST);
      end
    end
    if (w_fall) begin
      w_sck  = 1'b0;
      w_mosi = (r_state != DATA) && r_tx[31];
      w_tx   = {r_tx[30:0], 1'b0};
    end
    if (w_stop) begin
      w_state = DONE;
      w_cs_n  = 1'b1;
      w_mosi  = 1'b0;
      w_last  = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b1;
    end
    if (r_pend) begin
      w_pend = 1'b0;
      w_wr   = 1'b1;
      w_addr = r_k[12:0];
      w_be   = 4'b0001 << r_k[1:0];
      w_data = {4{r_rx}};
      w_k    = r_k + 14'd1;
    end
  end
  // state and datapath registers, cleared immediately by rst_ni
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_sck   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_tx    <= '0;
      r_cnt   <= '0;
      r_rx    <= '0;
      r_pend  <= 1'b0;
      r_last  <= 1'b0;
      r_k     <= '0;
      r_wr    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_sck   <= w_sck;
      r_cs_n  <= w_cs_n;
      r_mosi  <= w_mosi;
      r_tx    <= w_tx;
      r_cnt   <= w_cnt;
      r_rx    <= w_rx;
      r_pend  <= w_pend;
      r_last  <= w_last;
      r_k     <= w_k;
      r_wr    <= w_wr;
      r_be    <= w_be;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end
  assign bus.spi_sck_o    = r_sck;
  assign bus.spi_cs_no    = r_cs_n;
  assign bus.spi_mosi_o   = r_mosi;
  assign bus.mem_write_o  = r_wr;
  assign bus.mem_be_sel_o = r_be;
  assign bus.mem_addr_o   = r_addr;
  assign bus.mem_data_o   = r_data;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: two loader instances against flash and memory models with random data
module tb_flash_boot_loader;
  localparam logic [54:0] RST_OUTS = {1'b1, 54'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] start = '0;
  logic [1:0] busy, done;
  logic [7:0] fdata [2][8];
  logic [54:0] outs [2];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int NB = (g == 0) ? 8 : 4;
    localparam logic [23:0] BASE = (g == 0) ? 24'h012345 : 24'hFFFFFE;
    localparam int DIV = (g == 0) ? 2 : 1;
    flash_boot_loader_if bus();
    flash_boot_loader #(.NUM_BYTES(NB), .FLASH_BASE(BASE), .SCK_DIV(DIV)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start[g]), .bus(bus), .busy_o(busy[g]), .done_o(done[g])
    );
    assign outs[g] = {bus.spi_cs_no, bus.spi_sck_o, bus.spi_mosi_o, bus.mem_write_o, bus.mem_be_sel_o,
                      bus.mem_addr_o, bus.mem_data_o, busy[g], done[g]};
    int rises = 0, wcnt = 0, run = 0, lr = 0, bi;
    logic pcs = 1'b1, psck = 1'b0, pbusy = 1'b0;
    logic [31:0] sh = '0;
    logic [31:0] memw [2];
    logic [7:0] fb;
    assign bi = rises - 32;
    assign fb = fdata[g][bi[5:3]];
    assign bus.spi_miso_i = (bi >= 0 && bi < 8 * NB) ? fb[3'd7 - bi[2:0]] : 1'b0;
    always @(negedge clk) begin
      if (!rst_n) run = 0;
      else begin
        if (pcs && !bus.spi_cs_no) begin
          rises = 0; wcnt = 0; sh = '0; run = 0; memw[0] = '0; memw[1] = '0;
        end
        if (!bus.spi_cs_no) begin
          if (bus.spi_sck_o != psck) begin
            chk($sformatf("u%0d_half_period", g), 64'(run), 64'(DIV));
            run = 1;
          end else run++;
        end else if (run > 0) begin
          chk($sformatf("u%0d_last_half_period", g), 64'(run), 64'(DIV));
          run = 0;
        end
        if (bus.spi_sck_o && !psck && !bus.spi_cs_no) begin
          if (rises < 32) sh = {sh[30:0], bus.spi_mosi_o};
          else chk($sformatf("u%0d_mosi_in_data", g), 64'(bus.spi_mosi_o), 64'(0));
          rises++;
          lr = cyc;
        end
        if (bus.mem_write_o) begin
          chk($sformatf("u%0d_wr_busy", g), 64'(busy[g] | pbusy), 64'(1));
          if (wcnt < NB) begin
            chk($sformatf("u%0d_addr%0d", g, wcnt), 64'(bus.mem_addr_o), 64'(wcnt));
            chk($sformatf("u%0d_be%0d", g, wcnt), 64'(bus.mem_be_sel_o), 64'(1 << (wcnt % 4)));
            chk($sformatf("u%0d_data%0d", g, wcnt), 64'(bus.mem_data_o), 64'({4{fdata[g][wcnt]}}));
          end else chk($sformatf("u%0d_extra_write", g), 64'(wcnt), 64'(NB - 1));
          for (int l = 0; l < 4; l++)
            if (bus.mem_be_sel_o[l]) memw[bus.mem_addr_o[2]][8*l +: 8] = bus.mem_data_o[8*l +: 8];
          wcnt++;
        end
        if (pbusy && !busy[g]) begin
          chk($sformatf("u%0d_tail_cycles", g), 64'(cyc - lr), 64'(2 * DIV));
          chk($sformatf("u%0d_sck_rises", g), 64'(rises), 64'(32 + 8 * NB));
          chk($sformatf("u%0d_write_count", g), 64'(wcnt), 64'(NB));
          chk($sformatf("u%0d_cmd_addr", g), 64'(sh), 64'({8'h03, BASE}));
          for (int j = 0; j < NB / 4; j++)
            chk($sformatf("u%0d_word%0d", g, j), 64'(memw[j]),
                64'({fdata[g][4*j+3], fdata[g][4*j+2], fdata[g][4*j+1], fdata[g][4*j]}));
        end
      end
      pcs = bus.spi_cs_no;
      psck = bus.spi_sck_o;
      pbusy = busy[g];
    end
  end
  task automatic chk_rst(input string t);
    for (int i = 0; i < 2; i++) chk($sformatf("%s_u%0d", t, i), 64'(outs[i]), 64'(RST_OUTS));
  endtask
  task automatic go(input logic [1:0] m);
    @(negedge clk) start = m;
    @(negedge clk) start = '0;
    chk("go_busy", 64'(busy & m), 64'(m));
    chk("go_done_clear", 64'(done & m), 64'(0));
  endtask
  task automatic run_to_idle();
    int n = 0;
    while (busy !== 2'b00 && n < 3000) begin
      @(negedge clk);
      start = busy & (($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00);
      n++;
    end
    start = '0;
    @(negedge clk);
    chk("xfer_done", 64'({busy, done}), 64'(4'b0011));
  endtask
  task automatic load_data(input logic use_5a);
    for (int k = 0; k < 8; k++) begin
      fdata[0][k] = use_5a ? 8'h5A : 8'hA0 + 8'(k);
      fdata[1][k] = 8'($urandom);
    end
  endtask
  initial begin
    load_data(1'b0);
    repeat (3) @(posedge clk);
    #1 chk_rst("rst_idle");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_rst("idle_no_start");
    go(2'b11);
    run_to_idle();
    repeat (10) begin
      @(negedge clk);
      chk("done_hold", 64'({busy, done}), 64'(4'b0011));
    end
    load_data(1'b1);
    go(2'b11);
    run_to_idle();
    load_data(1'b0);
    go(2'b01);
    repeat (60) @(negedge clk);
    go(2'b10);
    repeat (78) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_in_data");
    repeat (5) begin
      @(negedge clk);
      chk_rst("rst_hold");
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk_rst("post_rst_quiet");
    end
    load_data(1'b0);
    go(2'b11);
    run_to_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
